div3_iter_seq: RTL and testbench



---
 rtl/div3_pkg.sv | 25 ++
 rtl/div3_digit.sv | 35 +++
 rtl/div3_iter_seq.sv | 122 ++++++++++++
 tb/tb_div3_iter_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div3_pkg.sv
//------------------------------------------------------------------------------
// div3_pkg : shared types and sizing constants for the divide-by-3 unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package div3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 64;
  localparam int DIGITS    = DEF_WIDTH / 4;
  localparam int CNT_W     = $clog2(DIGITS);

  function automatic int digits_of(input int width);
    return width / 4;
  endfunction

endpackage : div3_pkg

`default_nettype wire

// File: rtl/div3_digit.sv
//------------------------------------------------------------------------------
// div3_digit : one radix-16 digit of x/3, {rem,nib} -> quotient digit, remainder
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div3_digit
  import div3_pkg::*;
(
  input  logic [1:0] rem,
  input  logic [3:0] nib,
  output logic [3:0] qd,
  output logic [1:0] rem_n
);

  logic [2:0] w_r;

  // Bit-serial restoring division by 3; w_r stays below 3 between steps,
  // so shifting in one dividend bit never overflows 3 bits.
  always_comb begin
    qd  = 4'd0;
    w_r = {1'b0, rem};
    for (int i = 3; i >= 0; i--) begin
      w_r = {w_r[1:0], nib[i]};
      if (w_r >= 3'd3) begin
        qd[i] = 1'b1;
        w_r   = w_r - 3'd3;
      end
    end
    rem_n = w_r[1:0];
  end

endmodule : div3_digit

`default_nettype wire

// File: rtl/div3_iter_seq.sv
//------------------------------------------------------------------------------
// div3_iter_seq : handshaked iterative x/3, one radix-16 digit per cycle, MSB first
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div3_iter_seq
  import div3_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       out_r,
  output logic             busy
);

  localparam int                 c_digits   = digits_of(WIDTH);
  localparam int                 c_cnt_w    = $clog2(c_digits);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(c_digits - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_q;
  logic [1:0]         r_rem;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;
  logic [WIDTH-1:0]   r_out_q;
  logic [1:0]         r_out_r;

  logic [3:0]         w_nib;
  logic [3:0]         w_qd;
  logic [1:0]         w_rem_n;
  logic [WIDTH-1:0]   w_q_next;

  assign w_nib    = r_x[WIDTH-1 -: 4];
  assign w_q_next = {r_q[WIDTH-5:0], w_qd};

  div3_digit u_digit (
    .rem   (r_rem),
    .nib   (w_nib),
    .qd    (w_qd),
    .rem_n (w_rem_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_q         <= '0;
      r_rem       <= 2'd0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_q     <= '0;
      r_out_r     <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x        <= in_x;
            r_q        <= '0;
            r_rem      <= 2'd0;
            r_cnt      <= c_cnt_init;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          r_x   <= {r_x[WIDTH-5:0], 4'd0};
          r_q   <= w_q_next;
          r_rem <= w_rem_n;
          if (r_cnt == '0) begin
            // Result registers are separate so they hold through the next job.
            r_out_q     <= w_q_next;
            r_out_r     <= w_rem_n;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_q     = r_out_q;
  assign out_r     = r_out_r;

  a_rem_legal : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == RUN) |-> (r_rem != 2'd3));

endmodule : div3_iter_seq

`default_nettype wire

// File: tb/tb_div3_iter_seq.sv
//------------------------------------------------------------------------------
// tb_div3_iter_seq : directed self-checking bench for div3_iter_seq (WIDTH=64)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_div3_iter_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_q;
  logic [1:0]  out_r;
  logic        busy;

  logic [1:0]  t_rem = 2'd0;
  logic [3:0]  t_nib = 4'd0;
  logic [3:0]  t_qd;
  logic [1:0]  t_rem_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div3_iter_seq #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .busy      (busy)
  );

  div3_digit u_dig (
    .rem   (t_rem),
    .nib   (t_nib),
    .qd    (t_qd),
    .rem_n (t_rem_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the first negedge after the accepting edge.
  task automatic wait_result(input string tag, input logic [63:0] eq, input logic [1:0] er);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), 64'd16);
    check({tag, ":valid"},   64'(out_valid), 64'd1);
    check({tag, ":q"},       out_q, eq);
    check({tag, ":r"},       64'(out_r), 64'(er));
  endtask

  task automatic start_job(input string tag, input logic [63:0] x);
    @(negedge clk);
    check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_x     = x;
    @(negedge clk);
    in_valid = 1'b0;
    in_x     = ~x;
    check({tag, ":busy"}, 64'(busy), 64'd1);
  endtask

  task automatic run_job(input string tag, input logic [63:0] x,
                         input logic [63:0] eq, input logic [1:0] er);
    start_job(tag, x);
    wait_result(tag, eq, er);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":cons_valid"}, 64'(out_valid), 64'd0);
    check({tag, ":cons_ready"}, 64'(in_ready), 64'd1);
    check({tag, ":hold_q"},     out_q, eq);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst:in_ready",  64'(in_ready), 64'd1);
    check("rst:out_valid", 64'(out_valid), 64'd0);
    check("rst:busy",      64'(busy), 64'd0);
    check("rst:out_q",     out_q, 64'd0);
    check("rst:out_r",     64'(out_r), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Digit logic, all 48 legal (rem, nib) pairs
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 16; n++) begin
        int d;
        logic [5:0] e;
        t_rem = 2'(r);
        t_nib = 4'(n);
        d = r * 16 + n;
        e = {4'(d / 3), 2'(d % 3)};
        #1;
        check($sformatf("digit r%0d n%0d", r, n), 64'({t_qd, t_rem_n}), 64'(e));
      end
    end

    // Directed jobs
    run_job("zero",  64'd0,   64'd0,  2'd0);
    run_job("one",   64'd1,   64'd0,  2'd1);
    run_job("two",   64'd2,   64'd0,  2'd2);
    run_job("x16",   64'd16,  64'd5,  2'd1);
    run_job("x100",  64'd100, 64'd33, 2'd1);
    run_job("all_f", 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555, 2'd0);
    run_job("all_fe",64'hFFFF_FFFF_FFFF_FFFE, 64'h5555_5555_5555_5554, 2'd2);
    run_job("msb",   64'h8000_0000_0000_0000, 64'h2AAA_AAAA_AAAA_AAAA, 2'd2);

    // Backpressure: result held 5 cycles, new operand refused until consumed
    start_job("bp", 64'd100);
    wait_result("bp", 64'd33, 2'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_x     = 64'd48;
      @(negedge clk);
      check($sformatf("bp%0d:valid", i),    64'(out_valid), 64'd1);
      check($sformatf("bp%0d:q", i),        out_q, 64'd33);
      check($sformatf("bp%0d:r", i),        64'(out_r), 64'd1);
      check($sformatf("bp%0d:in_ready", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp:idle_ready", 64'(in_ready), 64'd1);
    check("bp:idle_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_x     = 64'd5;
    check("bp:accepted", 64'(busy), 64'd1);
    wait_result("bp_next", 64'd16, 2'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_next:cons", 64'(out_valid), 64'd0);

    // out_ready already high on entry to DONE: consumed in that cycle
    start_job("rdy_hi", 64'd3);
    out_ready = 1'b1;
    wait_result("rdy_hi", 64'd1, 2'd0);
    @(negedge clk);
    check("rdy_hi:cons", 64'(out_valid), 64'd0);
    check("rdy_hi:idle", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    // Reset in the middle of a job
    start_job("rst_mid", 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid:valid",    64'(out_valid), 64'd0);
    check("rst_mid:in_ready", 64'(in_ready), 64'd1);
    check("rst_mid:busy",     64'(busy), 64'd0);
    check("rst_mid:out_q",    out_q, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) check($sformatf("rst_mid:stale%0d", i), 64'(out_valid), 64'd0);
    end
    check("rst_mid:no_result", 64'(out_valid), 64'd0);
    run_job("after_rst", 64'd7, 64'd2, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_div3_iter_seq

`default_nettype wire
